// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the immediate packer and extender.
package imm_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [1:0] imm_src_t;

  localparam imm_src_t IMM_I = 2'b00;
  localparam imm_src_t IMM_S = 2'b01;
  localparam imm_src_t IMM_B = 2'b10;
  localparam imm_src_t IMM_J = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic            err;
  } imm_beat_t;

  // True when v[XLEN-1:lsb] are all equal, i.e. v fits in an (lsb+1)-bit signed field.
  function automatic logic upper_uniform(input logic [XLEN-1:0] v, input int unsigned lsb);
    logic [XLEN-1:0] m;
    m = {XLEN{1'b1}} << lsb;
    return ((v & m) == m) || ((v & m) == '0);
  endfunction

endpackage

// File: rtl/imm_pack_comb.sv
// Combinational immediate packer: scatters imm into the selected field layout and flags
// immediates that the layout cannot represent.
module imm_pack_comb
  import imm_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic [XLEN-1:0] tmpl,
  input  logic [XLEN-1:0] imm,
  input  imm_src_t        imm_src,
  output logic [XLEN-1:0] instr_c,
  output logic            err_c
);

  logic range_err;

  always_comb begin
    instr_c   = tmpl;
    range_err = 1'b0;
    case (imm_src)
      IMM_I: begin
        instr_c[31:20] = imm[11:0];
        range_err      = !upper_uniform(imm, 11);
      end
      IMM_S: begin
        instr_c[31:25] = imm[11:5];
        instr_c[11:7]  = imm[4:0];
        range_err      = !upper_uniform(imm, 11);
      end
      IMM_B: begin
        instr_c[31]    = imm[12];
        instr_c[30:25] = imm[10:5];
        instr_c[11:8]  = imm[4:1];
        instr_c[7]     = imm[11];
        range_err      = !upper_uniform(imm, 12) || imm[0];
      end
      IMM_J: begin
        instr_c[31]    = imm[20];
        instr_c[30:21] = imm[10:1];
        instr_c[20]    = imm[11];
        instr_c[19:12] = imm[19:12];
        range_err      = !upper_uniform(imm, 20) || imm[0];
      end
    endcase
    err_c = CHECK_EN && range_err;
  end

endmodule

// File: rtl/imm_pack_p.sv
// Pipelined immediate encoder: two valid/ready register stages around the packer,
// plus a saturating count of errored beats delivered downstream.
module imm_pack_p
  import imm_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8,
  parameter bit          CHECK_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_instr,
  input  logic [XLEN-1:0]      in_imm,
  input  imm_src_t             in_immSrc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_instr,
  output logic                 out_err,
  input  logic                 clr_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  imm_beat_t pack_c;
  imm_beat_t s1_beat;
  logic      s1_valid;
  logic      s1_en;
  logic      s2_en;

  imm_pack_comb #(
    .CHECK_EN (CHECK_EN)
  ) u_pack (
    .tmpl    (in_instr),
    .imm     (in_imm),
    .imm_src (in_immSrc),
    .instr_c (pack_c.instr),
    .err_c   (pack_c.err)
  );

  // Each stage advances when the stage ahead of it is empty or draining.
  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_beat  <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) s1_beat <= pack_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= s1_beat.instr;
        out_err   <= s1_beat.err;
      end
    end
  end

  // Clear wins over a same-cycle increment; count holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_pack_p.sv
// Self-checking bench for imm_pack_p: directed vectors, counter saturation/clear,
// backpressure, mid-flight reset and a random scoreboard run with round-trip decode.
module tb_imm_pack_p;

  localparam int unsigned CW   = 8;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_instr = '0;
  logic [31:0]   in_imm = '0;
  logic [1:0]    in_immSrc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic          out_err;
  logic          clr_cnt = 1'b0;
  logic [CW-1:0] err_cnt;

  imm_pack_p #(.ERR_CNT_W(CW), .CHECK_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_imm    (in_imm),
    .in_immSrc (in_immSrc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .clr_cnt   (clr_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic [1:0]  src;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_out = 0;
  int          model_cnt = 0;
  bit          acc = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_instr = '0;
  logic [31:0] last_instr = '0;
  logic        last_err = 1'b0;

  logic [31:0] bnd_imm [14] = '{32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F800, 32'hFFFF_F7FF,
                                32'h0000_07FF, 32'hFFFF_F7FF,
                                32'h0000_0FFE, 32'h0000_1000, 32'hFFFF_F000, 32'h0000_0001,
                                32'h000F_FFFE, 32'hFFF0_0000, 32'hFFEF_FFFE, 32'h0000_0101};
  logic [1:0]  bnd_src [14] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1,
                                2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Reference layout written as whole-word concatenations.
  function automatic logic [31:0] model_pack(input logic [31:0] t, input logic [31:0] im,
                                             input logic [1:0] s);
    case (s)
      2'd0:    return {im[11:0], t[19:0]};
      2'd1:    return {im[11:5], t[24:12], im[4:0], t[6:0]};
      2'd2:    return {im[12], im[10:5], t[24:12], im[4:1], im[11], t[6:0]};
      default: return {im[20], im[10:1], im[11], im[19:12], t[11:0]};
    endcase
  endfunction

  // Representability judged by signed numeric range.
  function automatic logic model_err(input logic [31:0] im, input logic [1:0] s);
    int v;
    v = $signed(im);
    case (s)
      2'd0, 2'd1: return (v < -2048) || (v > 2047);
      2'd2:       return (v < -4096) || (v > 4095) || im[0];
      default:    return (v < -1048576) || (v > 1048575) || im[0];
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] i, input logic [1:0] s);
    case (s)
      2'd0:    return {{20{i[31]}}, i[31:20]};
      2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  // Observe the handshakes that the coming rising edge will complete.
  task automatic eval();
    exp_t e;
    logic e_err;
    acc = 1'b0;
    chk("err_cnt", 32'(err_cnt), 32'(model_cnt));
    if (stall_prev) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_instr", out_instr, held_instr);
    end
    stall_prev = out_valid && !out_ready;
    held_instr = out_instr;
    if (out_valid && out_ready) begin
      e_err = out_err;
      chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        e_err = e.err;
        chk("out_instr", out_instr, e.instr);
        chk("out_err", 32'(out_err), 32'(e.err));
        if (!e.err) chk("roundtrip", extend(out_instr, e.src), e.imm);
        last_instr = out_instr;
        last_err   = out_err;
        n_out++;
      end
      if (!clr_cnt && e_err && model_cnt != int'(CMAX)) model_cnt++;
    end
    if (clr_cnt) model_cnt = 0;
    if (in_valid && in_ready) begin
      sbq.push_back('{model_pack(in_instr, in_imm, in_immSrc), model_err(in_imm, in_immSrc),
                      in_imm, in_immSrc});
      acc = 1'b1;
    end
  endtask

  task automatic tick();
    #1;
    eval();
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] t, input logic [31:0] im, input logic [1:0] s,
                       input int max_cyc, output bit ok);
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_instr  = t;
    in_imm    = im;
    in_immSrc = s;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      if (acc) ok = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sbq.size() != 0; i++) tick();
    tick();
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic send_directed(input string tag, input logic [31:0] t, input logic [31:0] im,
                               input logic [1:0] s, input logic [31:0] exp_i, input logic exp_e);
    bit ok;
    int n0;
    int lat;
    out_ready = 1'b1;
    n0 = n_out;
    offer(t, im, s, 20, ok);
    chk({tag, "_acc"}, 32'(ok), 32'd1);
    lat = 0;
    while (n_out == n0 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_instr"}, last_instr, exp_i);
    chk({tag, "_err"}, 32'(last_err), 32'(exp_e));
  endtask

  function automatic logic [31:0] rand_imm(input logic [1:0] s);
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return r;
    case (s)
      2'd0, 2'd1: return {{20{r[11]}}, r[11:0]};
      2'd2:       return {{19{r[12]}}, r[12:1], 1'b0};
      default:    return {{11{r[20]}}, r[20:1], 1'b0};
    endcase
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          idx;
    int          n0;
    int          n_acc;
    int          cyc;
    logic [1:0]  s;
    logic [31:0] bp_imm [3];

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send_directed("vec_i", 32'h0000_0013, 32'hFFFF_F800, 2'd0, 32'h8000_0013, 1'b0);
    send_directed("vec_s", 32'h0000_2023, 32'h0000_0044, 2'd1, 32'h0400_2223, 1'b0);
    send_directed("vec_j", 32'h0000_006F, 32'h000F_FFFE, 2'd3, 32'h7FFF_F06F, 1'b0);
    send_directed("vec_jerr", 32'h0000_006F, 32'h0010_0000, 2'd3, 32'h8000_006F, 1'b1);
    tick();
    chk("cnt_after_jerr", 32'(err_cnt), 32'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) offer($urandom, bnd_imm[i], bnd_src[i], 20, ok);
    drain();

    for (int i = 0; i < 300; i++) offer(32'h0000_0063, 32'h0000_0003, 2'd2, 20, ok);
    drain();
    chk("cnt_sat", 32'(err_cnt), CMAX);

    offer(32'h0000_0063, 32'h0000_0003, 2'd2, 20, ok);
    tick();
    chk("clr_fire", 32'(out_valid && out_err), 32'd1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    tick();
    chk("cnt_clr", 32'(err_cnt), 32'd0);

    bp_imm = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid  = (idx < 3);
      in_instr  = 32'h0000_0013;
      in_imm    = bp_imm[idx < 3 ? idx : 0];
      in_immSrc = 2'd0;
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      in_valid = 1'b1;
      in_imm   = bp_imm[idx];
      tick();
      if (acc) idx++;
    end
    drain();
    chk("bp_order_last", last_instr, 32'h0030_0013);

    out_ready = 1'b0;
    offer(32'h0000_0013, 32'h0000_0055, 2'd0, 20, ok);
    offer(32'h0000_0013, 32'h0000_0066, 2'd0, 20, ok);
    chk("mid_two_inside", 32'(sbq.size()), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_instr", out_instr, 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    sbq.delete();
    model_cnt  = 0;
    stall_prev = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (6) tick();
    chk("mid_no_stale", 32'(n_out - n0), 32'd0);

    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        s         = 2'($urandom_range(0, 3));
        in_valid  = 1'b1;
        in_instr  = $urandom;
        in_immSrc = s;
        in_imm    = rand_imm(s);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_cnt   = ($urandom_range(0, 199) == 0);
      tick();
      if (acc) begin
        in_valid = 1'b0;
        n_acc++;
      end
      cyc++;
    end
    clr_cnt = 1'b0;
    chk("rand_count", 32'(n_acc), 32'd10000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
